fetch_pc_unit: RTL and testbench

Fetch-stage program-counter and IF/ID register block, directly upstream of the control unit. It consumes the control unit's `pc_sel`, `fetch_pc_enable`, `flush`, `freeze_cu` and `pop_pc2`/`pop_pc1` strobes. It also consumes the 16-bit popped stack words from the memory stage. It produces the instruction address, plus the registered instruction and return address that decode and the call/interrupt push sequencers use.

---
 rtl/fetch_pc_unit.sv | 120 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with IF/ID pipeline register and two-pop return reload.
// Redirect priority: return load, jump, interrupt, reset vector, hold, increment.
module fetch_pc_unit #(
    parameter int unsigned     PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter logic [PC_W-1:0] INT_VECTOR   = PC_W'(2),
    parameter logic [15:0]     NOP          = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_pc_enable,
    input  logic            freeze_cu,
    input  logic            flush,
    input  logic [1:0]      pc_sel,
    input  logic [PC_W-1:0] jump_target,
    input  logic            pop_pc2,
    input  logic            pop_pc1,
    input  logic [15:0]     pop_data,
    input  logic [15:0]     instr_in,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc_next,
    output logic            ret_pending
);

    localparam int unsigned HI_W = PC_W - 16;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        RET_HI     = 2'd1,
        RET_BUBBLE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HI_W-1:0]   hi_reg;
    logic [HI_W-1:0]   hi_next;
    logic [PC_W-1:0]   pc_plus1;
    logic [PC_W-1:0]   pc_next;
    logic [15:0]       ifid_instr_next;
    logic [PC_W-1:0]   ifid_pc_next_next;
    logic              ret_load;

    // Return FSM and high-half capture; pop_pc1 wins over a simultaneous pop_pc2
    always_comb begin
        state_next = state;
        hi_next    = hi_reg;
        ret_load   = 1'b0;
        case (state)
            RUN: begin
                if (pop_pc1) begin
                    ret_load   = 1'b1;
                    state_next = RET_BUBBLE;
                end else if (pop_pc2) begin
                    hi_next    = pop_data[HI_W-1:0];
                    state_next = RET_HI;
                end
            end
            RET_HI: begin
                if (pop_pc1) begin
                    ret_load   = 1'b1;
                    state_next = RET_BUBBLE;
                end else if (pop_pc2) begin
                    hi_next    = pop_data[HI_W-1:0];
                end
            end
            RET_BUBBLE: state_next = RUN;
            default:    state_next = RUN;
        endcase
    end

    // PC next value
    always_comb begin
        pc_plus1 = pc + PC_W'(1);
        pc_next  = pc;
        if (ret_load) begin
            if (state == RET_HI) pc_next = {hi_reg, pop_data};
            else                 pc_next = {{HI_W{1'b0}}, pop_data};
        end else begin
            case (pc_sel)
                2'b11:   pc_next = jump_target;
                2'b10:   pc_next = INT_VECTOR;
                2'b01:   pc_next = RESET_VECTOR;
                default: pc_next = fetch_pc_enable ? pc_plus1 : pc;
            endcase
        end
    end

    // IF/ID next value: bubble beats freeze, return address tracks even on a bubble
    always_comb begin
        ifid_instr_next   = ifid_instr;
        ifid_pc_next_next = ifid_pc_next;
        if (flush || (state == RET_BUBBLE) || ret_load) begin
            ifid_instr_next   = NOP;
            ifid_pc_next_next = pc_plus1;
        end else if (!freeze_cu) begin
            ifid_instr_next   = instr_in;
            ifid_pc_next_next = pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            hi_reg       <= '0;
            pc           <= RESET_VECTOR;
            ifid_instr   <= NOP;
            ifid_pc_next <= '0;
            ret_pending  <= 1'b0;
        end else begin
            state        <= state_next;
            hi_reg       <= hi_next;
            pc           <= pc_next;
            ifid_instr   <= ifid_instr_next;
            ifid_pc_next <= ifid_pc_next_next;
            ret_pending  <= (state_next != RUN);
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: fetch, wrap/hold, call/flush/freeze, return reload, reset.
module tb_fetch_pc_unit;

    localparam int unsigned PC_W = 32;
    localparam logic [15:0] NOP  = 16'hDEAD;
    localparam logic [15:0] MEMX = 16'h5A00;

    logic            clk;
    logic            rst;
    logic            fetch_pc_enable;
    logic            freeze_cu;
    logic            flush;
    logic [1:0]      pc_sel;
    logic [PC_W-1:0] jump_target;
    logic            pop_pc2;
    logic            pop_pc1;
    logic [15:0]     pop_data;
    logic [15:0]     instr_in;
    logic [PC_W-1:0] pc;
    logic [15:0]     ifid_instr;
    logic [PC_W-1:0] ifid_pc_next;
    logic            ret_pending;

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit #(
        .PC_W         (PC_W),
        .RESET_VECTOR (32'h0000_0000),
        .INT_VECTOR   (32'h0000_0002),
        .NOP          (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc_enable (fetch_pc_enable),
        .freeze_cu       (freeze_cu),
        .flush           (flush),
        .pc_sel          (pc_sel),
        .jump_target     (jump_target),
        .pop_pc2         (pop_pc2),
        .pop_pc1         (pop_pc1),
        .pop_data        (pop_data),
        .instr_in        (instr_in),
        .pc              (pc),
        .ifid_instr      (ifid_instr),
        .ifid_pc_next    (ifid_pc_next),
        .ret_pending     (ret_pending)
    );

    // Instruction memory model: word at address a is a[15:0] ^ MEMX
    assign instr_in = pc[15:0] ^ MEMX;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_pc_enable = 1'b0; freeze_cu = 1'b0; flush = 1'b0;
        pc_sel = 2'b00; jump_target = '0; pop_pc2 = 1'b0; pop_pc1 = 1'b0; pop_data = '0;
        #2 rst = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (ifid_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, NOP); end
        checks++; if (ifid_pc_next !== 32'h0) begin failures++; $display("FAIL reset_pcn got=%h exp=0", ifid_pc_next); end
        checks++; if (ret_pending !== 1'b0) begin failures++; $display("FAIL reset_retp got=%b exp=0", ret_pending); end
        step(); step();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_hold_pc got=%h exp=0", pc); end
        @(negedge clk);
        rst = 1'b0 + 1'b1;
        fetch_pc_enable = 1'b1;
        #1;
    endtask

    task automatic test_seq_fetch();
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (pc !== PC_W'(k)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, pc, PC_W'(k)); end
            checks++; if (ifid_instr !== (16'(k - 1) ^ MEMX)) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, ifid_instr, 16'(k - 1) ^ MEMX); end
            checks++; if (ifid_pc_next !== PC_W'(k)) begin failures++; $display("FAIL seq_pcn[%0d] got=%h exp=%h", k, ifid_pc_next, PC_W'(k)); end
        end
    endtask

    task automatic test_wrap_hold();
        pc_sel = 2'b11; jump_target = 32'hFFFF_FFFF;
        step();
        checks++; if (pc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL jump_ones got=%h exp=ffffffff", pc); end
        checks++; if (ifid_pc_next !== 32'h5) begin failures++; $display("FAIL jump_pcn got=%h exp=5", ifid_pc_next); end
        pc_sel = 2'b00;
        step();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
        checks++; if (ifid_pc_next !== 32'h0) begin failures++; $display("FAIL wrap_pcn got=%h exp=0", ifid_pc_next); end
        fetch_pc_enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (pc !== 32'h0) begin failures++; $display("FAIL hold_pc[%0d] got=%h exp=0", k, pc); end
        end
        pc_sel = 2'b10;
        step();
        checks++; if (pc !== 32'h2) begin failures++; $display("FAIL int_vec got=%h exp=2", pc); end
        pc_sel = 2'b01;
        step();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_vec got=%h exp=0", pc); end
        pc_sel = 2'b00; fetch_pc_enable = 1'b1;
    endtask

    task automatic test_call_flush();
        pc_sel = 2'b11; jump_target = 32'h0000_0100;
        step();
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL call_pc got=%h exp=100", pc); end
        pc_sel = 2'b00; flush = 1'b1; freeze_cu = 1'b1;
        step();
        checks++; if (ifid_instr !== NOP) begin failures++; $display("FAIL flush_instr got=%h exp=%h", ifid_instr, NOP); end
        checks++; if (ifid_pc_next !== 32'h101) begin failures++; $display("FAIL flush_pcn got=%h exp=101", ifid_pc_next); end
        flush = 1'b0; freeze_cu = 1'b0;
        step();
        checks++; if (ifid_instr !== 16'h5B01) begin failures++; $display("FAIL post_flush_instr got=%h exp=5b01", ifid_instr); end
        freeze_cu = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (ifid_instr !== 16'h5B01) begin failures++; $display("FAIL freeze_instr[%0d] got=%h exp=5b01", k, ifid_instr); end
            checks++; if (ifid_pc_next !== 32'h102) begin failures++; $display("FAIL freeze_pcn[%0d] got=%h exp=102", k, ifid_pc_next); end
            checks++; if (pc !== PC_W'(32'h103 + k)) begin failures++; $display("FAIL freeze_pc[%0d] got=%h exp=%h", k, pc, PC_W'(32'h103 + k)); end
        end
        freeze_cu = 1'b0;
    endtask

    task automatic test_return();
        pop_pc2 = 1'b1; pop_data = 16'h0001;
        step();
        checks++; if (ret_pending !== 1'b1) begin failures++; $display("FAIL ret_pend0 got=%b exp=1", ret_pending); end
        pop_pc2 = 1'b0; pop_data = 16'hFFFF;
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++; if (ret_pending !== 1'b1) begin failures++; $display("FAIL ret_pend%0d got=%b exp=1", k, ret_pending); end
        end
        pop_pc1 = 1'b1; pop_data = 16'h2345;
        step();
        checks++; if (pc !== 32'h0001_2345) begin failures++; $display("FAIL ret_pc got=%h exp=00012345", pc); end
        checks++; if (ifid_instr !== NOP) begin failures++; $display("FAIL ret_nop1 got=%h exp=%h", ifid_instr, NOP); end
        checks++; if (ret_pending !== 1'b1) begin failures++; $display("FAIL ret_pend3 got=%b exp=1", ret_pending); end
        pop_pc1 = 1'b0;
        step();
        checks++; if (ifid_instr !== NOP) begin failures++; $display("FAIL ret_nop2 got=%h exp=%h", ifid_instr, NOP); end
        checks++; if (ifid_pc_next !== 32'h0001_2346) begin failures++; $display("FAIL ret_bub_pcn got=%h exp=00012346", ifid_pc_next); end
        checks++; if (ret_pending !== 1'b0) begin failures++; $display("FAIL ret_pend_end got=%b exp=0", ret_pending); end
        step();
        checks++; if (ifid_instr !== 16'h7946) begin failures++; $display("FAIL ret_first_instr got=%h exp=7946", ifid_instr); end
        checks++; if (ifid_pc_next !== 32'h0001_2347) begin failures++; $display("FAIL ret_first_pcn got=%h exp=00012347", ifid_pc_next); end
    endtask

    task automatic test_simultaneous();
        pop_pc1 = 1'b1; pop_data = 16'h0010; pc_sel = 2'b11; jump_target = 32'h0000_0999;
        step();
        checks++; if (pc !== 32'h0000_0010) begin failures++; $display("FAIL pop_vs_jump got=%h exp=00000010", pc); end
        pop_pc1 = 1'b0; pc_sel = 2'b00;
        step();
        pop_pc2 = 1'b1; pop_data = 16'h0003;
        step();
        pop_pc1 = 1'b1; pop_pc2 = 1'b1; pop_data = 16'h0055;
        step();
        checks++; if (pc !== 32'h0003_0055) begin failures++; $display("FAIL both_pops got=%h exp=00030055", pc); end
        checks++; if (ret_pending !== 1'b1) begin failures++; $display("FAIL both_pend got=%b exp=1", ret_pending); end
        pop_pc1 = 1'b0; pop_pc2 = 1'b0;
        step();
        checks++; if (ret_pending !== 1'b0) begin failures++; $display("FAIL both_done got=%b exp=0", ret_pending); end
        pop_pc1 = 1'b1; pop_data = 16'h0077;
        step();
        checks++; if (pc !== 32'h0000_0077) begin failures++; $display("FAIL run_pop1 got=%h exp=00000077", pc); end
        pop_pc1 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_return();
        pop_pc2 = 1'b1; pop_data = 16'h00AB;
        step();
        pop_pc2 = 1'b0;
        checks++; if (ret_pending !== 1'b1) begin failures++; $display("FAIL mid_pend got=%b exp=1", ret_pending); end
        #2 rst = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL mid_rst_pc got=%h exp=0", pc); end
        checks++; if (ret_pending !== 1'b0) begin failures++; $display("FAIL mid_rst_pend got=%b exp=0", ret_pending); end
        checks++; if (ifid_instr !== NOP) begin failures++; $display("FAIL mid_rst_instr got=%h exp=%h", ifid_instr, NOP); end
        @(negedge clk);
        rst = 1'b1;
        pop_pc1 = 1'b1; pop_data = 16'h1234;
        step();
        checks++; if (pc !== 32'h0000_1234) begin failures++; $display("FAIL post_rst_pop1 got=%h exp=00001234", pc); end
        pop_pc1 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_wrap_hold();
        test_call_flush();
        test_return();
        test_simultaneous();
        test_reset_mid_return();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
